// File: rtl/nios_display_scanner_if.sv
// Bus between the Nios display PIOs and the digit scanner.
// master: the PIO side that supplies patterns and scan_en. slave: the scanner.
// The blink_mask signal exists only when DISPLAY_BLINK_EN is defined.
interface nios_display_scanner_if;
  logic       scan_en;
  logic [6:0] seg0_in;
  logic [6:0] seg1_in;
  logic [6:0] seg2_in;
  logic [6:0] seg3_in;
  logic [3:0] dp_in;
`ifdef DISPLAY_BLINK_EN
  logic [3:0] blink_mask;
`endif
  logic [6:0] out_seg;
  logic       out_dp;
  logic [3:0] digit_en;
  logic       frame_tick;

  modport master (
`ifdef DISPLAY_BLINK_EN
    output blink_mask,
`endif
    output scan_en, seg0_in, seg1_in, seg2_in, seg3_in, dp_in,
    input  out_seg, out_dp, digit_en, frame_tick
  );

  modport slave (
`ifdef DISPLAY_BLINK_EN
    input  blink_mask,
`endif
    input  scan_en, seg0_in, seg1_in, seg2_in, seg3_in, dp_in,
    output out_seg, out_dp, digit_en, frame_tick
  );
endinterface

// File: rtl/nios_display_scanner.sv
// Four-digit 7-segment scanner. Each slot is CLK_DIV cycles: BLANK_CYCLES of
// blanking (anti-ghosting) followed by the digit shown from a pattern snapshot
// taken when blanking ends, so PIO writes never tear a displayed digit.
// Optional feature macro: DISPLAY_BLINK_EN (adds blink_mask and BLINK_FRAMES).
module nios_display_scanner #(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
`ifdef DISPLAY_BLINK_EN
  ,
  parameter int BLINK_FRAMES     = 250
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nios_display_scanner_if.slave        bus
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // Counter value on the edge that ends blanking and starts the SHOW interval.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
  // Pin levels for "nothing lit / no digit selected".
  localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic             DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [3:0]       DIG_OFF  = (DIGIT_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       idx_reg;
  // The output registers double as the pattern/dp snapshot for the slot.
  logic [6:0]       out_seg_reg;
  logic             out_dp_reg;
  logic [3:0]       digit_en_reg;
  logic             frame_tick_reg;

  logic [6:0]       seg_sel;
  logic             dp_sel;
  logic [3:0]       digit_onehot;
  logic             digit_visible;

  // Select the pattern of the digit owning the current slot.
  always_comb begin
    seg_sel = bus.seg0_in;
    case (idx_reg)
      2'd1:    seg_sel = bus.seg1_in;
      2'd2:    seg_sel = bus.seg2_in;
      2'd3:    seg_sel = bus.seg3_in;
      default: seg_sel = bus.seg0_in;
    endcase
  end

  assign dp_sel = bus.dp_in[idx_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit_dec
      assign digit_onehot[gi] = (idx_reg == 2'(gi));
    end
  endgenerate

`ifdef DISPLAY_BLINK_EN
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  logic [FRM_W-1:0] frame_cnt_reg;
  logic             blink_phase_reg;
  logic             frame_end;

  // Last edge of digit 3's slot completes a frame.
  assign frame_end     = (cnt_reg == CNT_LAST) && (idx_reg == 2'd3);
  // Masked digits keep their enable off during the blink-off half-period.
  assign digit_visible = !(blink_phase_reg && bus.blink_mask[idx_reg]);

  // Count completed frames and toggle the blink phase every BLINK_FRAMES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (!bus.scan_en) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= !blink_phase_reg;
      end else begin
        frame_cnt_reg   <= frame_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign digit_visible = 1'b1;
`endif

  // Slot timing, BLANK/SHOW sequencing and registered pin-polarity outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      out_seg_reg    <= SEG_OFF;
      out_dp_reg     <= DP_OFF;
      digit_en_reg   <= DIG_OFF;
      frame_tick_reg <= 1'b0;
    end else if (!bus.scan_en) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      out_seg_reg    <= SEG_OFF;
      out_dp_reg     <= DP_OFF;
      digit_en_reg   <= DIG_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= 1'b0;
      if (cnt_reg == CNT_LAST) begin
        // End of slot: blank and advance to the next digit.
        cnt_reg      <= '0;
        idx_reg      <= idx_reg + 2'd1;
        state_reg    <= ST_BLANK;
        out_seg_reg  <= SEG_OFF;
        out_dp_reg   <= DP_OFF;
        digit_en_reg <= DIG_OFF;
        if (idx_reg == 2'd3) begin
          frame_tick_reg <= 1'b1;
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        if ((state_reg == ST_BLANK) && (cnt_reg == CNT_LOAD)) begin
          // Blanking over: snapshot this digit's pattern and select it.
          state_reg    <= ST_SHOW;
          out_seg_reg  <= seg_sel ^ SEG_OFF;
          out_dp_reg   <= dp_sel ^ DP_OFF;
          digit_en_reg <= digit_visible ? (digit_onehot ^ DIG_OFF) : DIG_OFF;
        end
      end
    end
  end

  assign bus.out_seg    = out_seg_reg;
  assign bus.out_dp     = out_dp_reg;
  assign bus.digit_en   = digit_en_reg;
  assign bus.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_nios_display_scanner.sv
// Self-checking bench for nios_display_scanner (CLK_DIV=10, BLANK_CYCLES=2,
// active-low segments and digits). A slot-arithmetic model predicts every
// output on every cycle; directed literal checks pin the model down.
module tb_nios_display_scanner;

  localparam int CLK_DIV = 10;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;
`ifdef DISPLAY_BLINK_EN
  localparam int BLINK_FRAMES = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg_v [4];

  int n_total = 0;
  int n_pass  = 0;

  nios_display_scanner_if bus ();

  assign bus.seg0_in = seg_v[0];
  assign bus.seg1_in = seg_v[1];
  assign bus.seg2_in = seg_v[2];
  assign bus.seg3_in = seg_v[3];

  nios_display_scanner #(
    .CLK_DIV          (CLK_DIV),
    .BLANK_CYCLES     (BLANK),
    .SEG_ACTIVE_LOW   (1),
    .DIGIT_ACTIVE_LOW (1)
`ifdef DISPLAY_BLINK_EN
    ,
    .BLINK_FRAMES     (BLINK_FRAMES)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: m_k counts enabled edges since reset/disable; the slot
  // position, digit and frame all follow from plain division of m_k.
  int         m_k    = 0;
  logic       m_show = 1'b0;
  int         m_digit = 0;
  logic [6:0] m_seg  = 7'h00;
  logic       m_dp   = 1'b0;
  logic       m_vis  = 1'b1;
  logic       m_ft   = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    int nk, c, slot, d;
    if (!reset_n || !bus.scan_en) begin
      m_k    <= 0;
      m_show <= 1'b0;
      m_ft   <= 1'b0;
    end else begin
      nk   = m_k + 1;
      c    = nk % CLK_DIV;
      slot = nk / CLK_DIV;
      d    = slot % 4;
      m_k    <= nk;
      m_show <= (c >= BLANK);
      m_ft   <= (nk % FRAME) == 0;
      if (c == BLANK) begin
        m_seg   <= seg_v[d];
        m_dp    <= bus.dp_in[d];
        m_digit <= d;
`ifdef DISPLAY_BLINK_EN
        m_vis   <= !((((slot / 4) / BLINK_FRAMES) % 2 == 1) && bus.blink_mask[d]);
`else
        m_vis   <= 1'b1;
`endif
      end
    end
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_en;
    exp_seg = m_show ? ~m_seg : 7'h7F;
    exp_dp  = m_show ? ~m_dp : 1'b1;
    exp_en  = (m_show && m_vis) ? ~(4'b0001 << m_digit) : 4'hF;
    check("model_out_seg",    bus.out_seg,    exp_seg);
    check("model_out_dp",     bus.out_dp,     exp_dp);
    check("model_digit_en",   bus.digit_en,   exp_en);
    check("model_frame_tick", bus.frame_tick, m_ft);
    check("one_digit_max",    ($countones(~bus.digit_en) <= 1), 1);
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int r;
    seg_v[0] = 7'h3F; seg_v[1] = 7'h06; seg_v[2] = 7'h5B; seg_v[3] = 7'h4F;
    bus.dp_in   = 4'b0001;
    bus.scan_en = 1'b0;
`ifdef DISPLAY_BLINK_EN
    bus.blink_mask = 4'b0000;
`endif
    // Reset hold, then release with scanning disabled.
    ticks(3);
    check("reset_seg", bus.out_seg, 7'h7F);
    check("reset_dp",  bus.out_dp, 1'b1);
    check("reset_en",  bus.digit_en, 4'hF);
    check("reset_ft",  bus.frame_tick, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      check("disabled_en",  bus.digit_en, 4'hF);
      check("disabled_seg", bus.out_seg, 7'h7F);
    end

    // Single slot and no-tearing sequence.
    bus.scan_en = 1'b1;
    ticks(1);  check("slot0_blank_en", bus.digit_en, 4'hF);
    ticks(1);  check("slot0_en",  bus.digit_en, 4'b1110);
               check("slot0_seg", bus.out_seg, 7'h40);
               check("slot0_dp",  bus.out_dp, 1'b0);
    ticks(8);  check("slot0_end_en", bus.digit_en, 4'hF);
    ticks(2);  check("slot1_en",  bus.digit_en, 4'b1101);
               check("slot1_seg", bus.out_seg, 7'h79);
               check("slot1_dp",  bus.out_dp, 1'b1);
    ticks(3);  seg_v[1] = 7'h5B;
    ticks(4);  check("no_tear_seg", bus.out_seg, 7'h79);
    ticks(1);  check("slot1_end_en", bus.digit_en, 4'hF);
    ticks(20); check("frame_tick_hi", bus.frame_tick, 1'b1);
    ticks(1);  check("frame_tick_lo", bus.frame_tick, 1'b0);
    ticks(1);  check("wrap_digit0_en", bus.digit_en, 4'b1110);
    ticks(10); check("slot1_new_seg", bus.out_seg, 7'h24);

    // Mid-slot disable during digit 2, then re-enable.
    ticks(12); check("slot2_en", bus.digit_en, 4'b1011);
    bus.scan_en = 1'b0;
    ticks(1);  check("disable_en",  bus.digit_en, 4'hF);
               check("disable_seg", bus.out_seg, 7'h7F);
    ticks(3);  check("disable_hold_en", bus.digit_en, 4'hF);
    bus.scan_en = 1'b1;
    ticks(1);  check("reenable_blank_en", bus.digit_en, 4'hF);
    ticks(1);  check("reenable_en",  bus.digit_en, 4'b1110);
               check("reenable_seg", bus.out_seg, 7'h40);

`ifdef DISPLAY_BLINK_EN
    // Blink digit 2: frames 0-1 shown, 2-3 suppressed, frame 4 shown again.
    bus.blink_mask = 4'b0100;
    bus.scan_en = 1'b0;
    ticks(1);
    bus.scan_en = 1'b1;
    ticks(62); check("blink_f1_d2", bus.digit_en, 4'b1011);
    ticks(40); check("blink_f2_d2", bus.digit_en, 4'hF);
    ticks(10); check("blink_f2_d3", bus.digit_en, 4'b0111);
    ticks(70); check("blink_f4_d2", bus.digit_en, 4'b1011);
`endif

    // Randomized traffic, disables and asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 40)       seg_v[$urandom_range(0, 3)] = 7'($urandom);
      else if (r < 55)  bus.dp_in = 4'($urandom);
      else if (r < 58)  bus.scan_en = 1'b0;
      else if (r < 90)  bus.scan_en = 1'b1;
`ifdef DISPLAY_BLINK_EN
      else if (r < 95)  bus.blink_mask = 4'($urandom);
`endif
      else if (r == 999) begin
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
      end
      ticks(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nios_display_scanner.md
Name: nios_display_scanner

Overview:
- Time-multiplexes four 7-segment patterns, produced by the Nios display PIO output ports, onto one shared segment bus with per-digit enables.
- Sits directly downstream of the display PIOs and drives the board's segment/anode pins.
- Uses a blank interval between digits to prevent ghosting.
- Snapshots each pattern at the start of its slot so software writes never tear a digit.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot. 1 kHz per digit at 50 MHz. Must be at least BLANK_CYCLES+1.
- BLANK_CYCLES, 500, cycles at the start of each slot with all outputs inactive. Must be at least 1.
- SEG_ACTIVE_LOW, 1, when 1, out_seg and out_dp are inverted at the pins.
- DIGIT_ACTIVE_LOW, 1, when 1, digit_en is active-low.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- scan_en  input  1  scanning enable; low forces blank.
- seg0_in..seg3_in  input  7 each  segment patterns, 1 = segment lit, bit0 = seg a.
- dp_in  input  4  decimal point per digit, 1 = lit.
- out_seg  output  7  shared segment bus (pin polarity).
- out_dp  output  1  shared decimal point (pin polarity).
- digit_en  output  4  digit select (pin polarity).
- frame_tick  output  1  one-cycle pulse per completed 4-digit frame.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n). All outputs are registered.
- Internal state:
  - cnt: slot counter, 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - idx: 2-bit digit index.
  - state: BLANK or SHOW.
  - pat/dp: snapshot registers.
- Reset:
  - cnt=0, idx=0, state=BLANK, frame_tick=0.
  - out_seg, out_dp and digit_en all at their inactive levels. With defaults: out_seg=7'h7F, out_dp=1, digit_en=4'hF.
- Counting: cnt increments every cycle while scan_en=1. At cnt==CLK_DIV-1 it wraps to 0.
- BLANK to SHOW, on the edge where cnt goes BLANK_CYCLES-1 to BLANK_CYCLES:
  - pat <= seg{idx}_in and dp <= dp_in[idx], sampled at that edge.
  - state=SHOW, digit_en[idx] active, all other digits inactive.
  - out_seg and out_dp driven from pat/dp.
- SHOW to BLANK, on the edge where cnt wraps CLK_DIV-1 to 0:
  - state=BLANK, all outputs inactive.
  - idx <= idx+1, wrapping 3 to 0.
- frame_tick: high for exactly the one cycle following the edge where idx wraps 3 to 0.
- Input changes during SHOW have no effect until the next slot of that digit. Never more than one digit is active.
- scan_en=0:
  - On the next edge: cnt=0, idx=0, state=BLANK, outputs inactive, frame_tick=0.
  - Held in that state while low.
  - After scan_en returns high, the first SHOW starts BLANK_CYCLES cycles later with digit 0.
- Reset mid-slot: immediate return to reset values (asynchronous). Slot timing restarts after reset_n deasserts.
- Polarity: applied only at the output registers. Pin value = logical value XOR the polarity parameter.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- When defined:
  - Adds input blink_mask [3:0] and parameter BLINK_FRAMES (default 250, frames per half-period).
  - An internal counter counts frame_tick pulses and toggles blink_phase every BLINK_FRAMES frames. blink_phase resets to 0 and clears on scan_en=0.
  - While blink_phase=1, a digit whose blink_mask bit is set keeps digit_en inactive during its SHOW interval. Slot timing is unchanged.
- When undefined: no port, no counter, all digits always shown.

Test Plan (CLK_DIV=10, BLANK_CYCLES=2, both polarities active-low):
- Reset hold then release, scan_en=0 -> out_seg=7'h7F, out_dp=1, digit_en=4'hF, frame_tick=0 for all cycles.
- Single slot: scan_en=1, seg0_in=7'h3F, dp_in=4'b0001 -> outputs blank for 2 cycles after release. Then for 8 cycles digit_en=4'b1110, out_seg=7'h40, out_dp=0. Then 2 blank cycles, then digit_en=4'b1101.
- No tearing: seg1_in changes 7'h06 to 7'h5B at cycle 3 of digit 1's SHOW interval -> out_seg stays 7'h79 for the rest of the slot. The next digit-1 slot shows 7'h24.
- Wrap: run 40 cycles -> frame_tick high for exactly one cycle after digit 3's slot ends. The next SHOW is digit_en=4'b1110. No cycle ever has two digit_en bits low.
- Mid-slot disable: scan_en=0 during digit 2 SHOW -> next cycle digit_en=4'hF, out_seg=7'h7F. Re-enable -> 2 blank cycles, then digit 0 shown.
- DISPLAY_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0100 -> frames 0-1 show all digits. Frames 2-3 keep digit_en[2] high during its slot while digits 0, 1 and 3 show normally. Frame 4 shows all digits again.
